// File: rtl/frame_pkg.sv
// Shared types and default geometry for the frame RAM loader and the scan-out painter.
package frame_pkg;

   localparam int PIX_W           = 8;
   localparam int RAM_ADDR_W      = 19;
   localparam int IMG_W_DEF       = 320;
   localparam int IMG_H_DEF       = 240;
   localparam int LINE_STRIDE_DEF = 320;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_FILL   = 2'd2,
      ST_DONE   = 2'd3
   } fw_state_e;

   // True when the whole raster lands inside the RAM and lines do not overlap.
   function automatic logic frame_fits(input int base, input int w, input int h,
                                       input int stride, input int aw);
      longint last_addr;
      last_addr = longint'(base) + longint'(h - 1) * longint'(stride) + longint'(w) - 64'sd1;
      return (stride >= w) && (last_addr < (64'sd1 <<< aw));
   endfunction

endpackage

// File: rtl/raster_addr_gen.sv
// Raster position tracker: x/y counters and a row-base accumulator producing the RAM address.
module raster_addr_gen
   import frame_pkg::*;
#(
   parameter int IMG_W       = IMG_W_DEF,
   parameter int IMG_H       = IMG_H_DEF,
   parameter int LINE_STRIDE = LINE_STRIDE_DEF,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_W      = RAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              step_i,
   input  logic              clear_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              last_o
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H + 1) : 1;
   localparam logic [XW-1:0]     X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0]     Y_LAST = YW'(IMG_H - 1);
   localparam logic [ADDR_W-1:0] BASE   = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(LINE_STRIDE);

   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] row_q, row_d;
   logic              x_end_s;

   // Next position: clear restarts at the base, each step advances one pixel in raster order.
   always_comb begin
      x_end_s = (x_q == X_LAST);
      x_d     = x_q;
      y_d     = y_q;
      row_d   = row_q;
      if (clear_i) begin
         x_d   = {XW{1'b0}};
         y_d   = {YW{1'b0}};
         row_d = BASE;
      end else if (step_i) begin
         if (x_end_s) begin
            x_d   = {XW{1'b0}};
            y_d   = y_q + YW'(1);
            row_d = row_q + STRIDE;
         end else begin
            x_d = x_q + XW'(1);
         end
      end else begin
         x_d = x_q;
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q   <= {XW{1'b0}};
         y_q   <= {YW{1'b0}};
         row_q <= BASE;
      end else begin
         x_q   <= x_d;
         y_q   <= y_d;
         row_q <= row_d;
      end
   end

   // Address of the current pixel and end-of-frame flag.
   always_comb begin
      addr_o = row_q + ADDR_W'(x_q);
      last_o = x_end_s && (y_q == Y_LAST);
   end

endmodule

// File: rtl/frame_writer.sv
// Frame RAM port-B loader: writes a streamed or constant-filled frame in raster order.
module frame_writer
   import frame_pkg::*;
#(
   parameter int IMG_W       = IMG_W_DEF,
   parameter int IMG_H       = IMG_H_DEF,
   parameter int LINE_STRIDE = LINE_STRIDE_DEF,
   parameter int BASE_ADDR   = 0,
   parameter int ADDR_W      = RAM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   input  logic              fill_en_i,
   input  logic [PIX_W-1:0]  fill_value_i,
   input  logic              abort_i,
   input  logic              s_valid_i,
   input  logic [PIX_W-1:0]  s_data_i,
   output logic              s_ready_o,
   output logic [ADDR_W-1:0] ram_address_o,
   output logic [PIX_W-1:0]  ram_data_o,
   output logic              ram_wren_o,
   output logic              busy_o,
   output logic              done_o
);

   if (!frame_fits(BASE_ADDR, IMG_W, IMG_H, LINE_STRIDE, ADDR_W)) begin : g_bad_cfg
      $fatal(1, "frame_writer: raster does not fit the RAM address space or stride < width");
   end

   fw_state_e         state_q;
   logic              fill_q;
   logic [PIX_W-1:0]  fill_val_q;
   logic              drain_q;
   logic              wren_q;
   logic [ADDR_W-1:0] addr_q;
   logic [PIX_W-1:0]  data_q;
   logic              busy_q;
   logic              done_q;

   logic              ready_s;
   logic              accept_s;
   logic              step_s;
   logic              start_ok_s;
   logic              last_s;
   logic [ADDR_W-1:0] gen_addr_s;
   logic [PIX_W-1:0]  pix_s;

   // Handshake and pixel-issue decode; drain_q blocks issue while the final write goes out.
   always_comb begin
      ready_s    = (state_q == ST_STREAM) && !abort_i && !drain_q;
      accept_s   = ready_s && s_valid_i;
      step_s     = accept_s || ((state_q == ST_FILL) && !drain_q);
      start_ok_s = (state_q == ST_IDLE) && start_i && !abort_i;
      if (fill_q) begin
         pix_s = fill_val_q;
      end else begin
         pix_s = s_data_i;
      end
   end

   raster_addr_gen #(
      .IMG_W       (IMG_W),
      .IMG_H       (IMG_H),
      .LINE_STRIDE (LINE_STRIDE),
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_W      (ADDR_W)
   ) u_raster (
      .clk     (clk),
      .rst_n   (rst_n),
      .step_i  (step_s),
      .clear_i (start_ok_s),
      .addr_o  (gen_addr_s),
      .last_o  (last_s)
   );

   // RAM port-B write register: one write per issued pixel, one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wren_q <= 1'b0;
         addr_q <= {ADDR_W{1'b0}};
         data_q <= {PIX_W{1'b0}};
      end else begin
         wren_q <= step_s;
         if (step_s) begin
            addr_q <= gen_addr_s;
            data_q <= pix_s;
         end
      end
   end

   // Frame sequencer with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         fill_q     <= 1'b0;
         fill_val_q <= {PIX_W{1'b0}};
         drain_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_ok_s) begin
                  fill_q     <= fill_en_i;
                  fill_val_q <= fill_value_i;
                  drain_q    <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= fill_en_i ? ST_FILL : ST_STREAM;
               end
            end
            ST_STREAM, ST_FILL: begin
               if (abort_i) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  drain_q <= 1'b0;
               end else if (drain_q) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  drain_q <= 1'b0;
               end else if (step_s && last_s) begin
                  drain_q <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               drain_q <= 1'b0;
            end
         endcase
      end
   end

   assign s_ready_o     = ready_s;
   assign ram_wren_o    = wren_q;
   assign ram_address_o = addr_q;
   assign ram_data_o    = data_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer on a small 4x3 raster with stride 8 at base 16.
module tb_frame_writer;

   localparam int W    = 4;
   localparam int H    = 3;
   localparam int STR  = 8;
   localparam int BASE = 16;
   localparam int AW   = 19;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start, fill_en, abort, s_valid;
   logic [7:0]    fill_value, s_data;
   logic          s_ready_o, ram_wren_o, busy_o, done_o;
   logic [AW-1:0] ram_address_o;
   logic [7:0]    ram_data_o;

   int vec = 0;
   int err = 0;
   int cyc = 0;

   logic [AW-1:0] wa[$];
   logic [7:0]    wd[$];
   int            wc[$];
   int            dc[$];
   logic [7:0]    exp_q[$];
   int            acc_cyc[$];

   frame_writer #(
      .IMG_W(W), .IMG_H(H), .LINE_STRIDE(STR), .BASE_ADDR(BASE), .ADDR_W(AW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .fill_en_i(fill_en),
      .fill_value_i(fill_value), .abort_i(abort), .s_valid_i(s_valid),
      .s_data_i(s_data), .s_ready_o(s_ready_o), .ram_address_o(ram_address_o),
      .ram_data_o(ram_data_o), .ram_wren_o(ram_wren_o), .busy_o(busy_o),
      .done_o(done_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every RAM write and done pulse with the cycle it was seen in.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ram_wren_o) begin
            wa.push_back(ram_address_o);
            wd.push_back(ram_data_o);
            wc.push_back(cyc);
         end
         if (done_o) dc.push_back(cyc);
      end
   end

   // Raster address of the k-th pixel of a frame.
   function automatic int exp_addr(input int k);
      return BASE + (k / W) * STR + (k % W);
   endfunction

   task automatic clear_rec();
      wa.delete(); wd.delete(); wc.delete(); dc.delete();
      exp_q.delete(); acc_cyc.delete();
   endtask

   // Start a stream frame and feed pixels until count have been accepted.
   task automatic feed(input int count, input int mode, input bit poke);
      int guard;
      guard = 0;
      @(negedge clk);
      start = 1'b1; fill_en = 1'b0; fill_value = 8'h00;
      while (exp_q.size() < count && guard < 200) begin
         @(negedge clk);
         start = 1'b0; fill_en = 1'b0;
         if (poke && exp_q.size() == 5) begin
            start = 1'b1; fill_en = 1'b1; fill_value = 8'h3C;
         end
         if (mode == 0)      s_valid = 1'b1;
         else if (mode == 1) s_valid = (guard % 2 == 0);
         else                s_valid = 1'($urandom_range(0, 1));
         s_data = 8'($urandom);
         #1;
         if (s_valid && s_ready_o) begin
            exp_q.push_back(s_data);
            acc_cyc.push_back(cyc);
         end
         guard++;
      end
      vec++;
      if (exp_q.size() != count) begin
         err++;
         $display("FAIL feed_accepts got=%0d want=%0d", exp_q.size(), count);
      end
   endtask

   task automatic run_stream(input int mode, input bit poke);
      clear_rec();
      feed(NPIX, mode, poke);
      @(negedge clk);
      s_valid = 1'b0; start = 1'b0; fill_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         start = (poke && done_o) ? 1'b1 : 1'b0;
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      vec++;
      if (wa.size() != NPIX) begin
         err++; $display("FAIL stream_m%0d_nwrites got=%0d want=%0d", mode, wa.size(), NPIX);
      end
      for (int i = 0; i < NPIX && i < wa.size() && i < exp_q.size(); i++) begin
         vec++;
         if (wa[i] !== AW'(exp_addr(i))) begin
            err++; $display("FAIL stream_m%0d_addr[%0d] got=%0d want=%0d", mode, i, wa[i], exp_addr(i));
         end
         vec++;
         if (wd[i] !== exp_q[i]) begin
            err++; $display("FAIL stream_m%0d_data[%0d] got=%h want=%h", mode, i, wd[i], exp_q[i]);
         end
         vec++;
         if (wc[i] != acc_cyc[i] + 1) begin
            err++; $display("FAIL stream_m%0d_latency[%0d] got=%0d want=%0d", mode, i, wc[i], acc_cyc[i] + 1);
         end
      end
      vec++;
      if (dc.size() != 1) begin
         err++; $display("FAIL stream_m%0d_done_count got=%0d want=1", mode, dc.size());
      end else if (wa.size() > 0) begin
         vec++;
         if (dc[0] != wc[wc.size()-1] + 1) begin
            err++; $display("FAIL stream_m%0d_done_cycle got=%0d want=%0d", mode, dc[0], wc[wc.size()-1] + 1);
         end
      end
      if (mode == 1 && wc.size() == NPIX) begin
         vec++;
         if (wc[NPIX-1] - wc[0] != 2 * (NPIX - 1)) begin
            err++; $display("FAIL stall_span got=%0d want=%0d", wc[NPIX-1] - wc[0], 2 * (NPIX - 1));
         end
      end
      vec++;
      if (busy_o !== 1'b0) begin
         err++; $display("FAIL stream_m%0d_busy_after got=%b want=0", mode, busy_o);
      end
   endtask

   task automatic test_reset();
      #3;
      vec++; if (s_ready_o !== 1'b0)       begin err++; $display("FAIL rst_s_ready got=%b want=0", s_ready_o); end
      vec++; if (ram_wren_o !== 1'b0)      begin err++; $display("FAIL rst_wren got=%b want=0", ram_wren_o); end
      vec++; if (ram_address_o !== '0)     begin err++; $display("FAIL rst_addr got=%0d want=0", ram_address_o); end
      vec++; if (ram_data_o !== 8'h00)     begin err++; $display("FAIL rst_data got=%h want=00", ram_data_o); end
      vec++; if (busy_o !== 1'b0)          begin err++; $display("FAIL rst_busy got=%b want=0", busy_o); end
      vec++; if (done_o !== 1'b0)          begin err++; $display("FAIL rst_done got=%b want=0", done_o); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_fill(input logic [7:0] val);
      int ready_seen;
      clear_rec();
      ready_seen = 0;
      @(negedge clk);
      start = 1'b1; fill_en = 1'b1; fill_value = val;
      @(negedge clk);
      start = 1'b0; fill_en = 1'b0; fill_value = 8'h00;
      for (int i = 0; i < 30 && dc.size() == 0; i++) begin
         s_valid = 1'b1;
         #1;
         if (s_ready_o) ready_seen++;
         @(negedge clk);
      end
      s_valid = 1'b0;
      repeat (2) @(negedge clk);
      vec++; if (ready_seen != 0) begin err++; $display("FAIL fill_s_ready got=%0d want=0", ready_seen); end
      vec++; if (wa.size() != NPIX) begin err++; $display("FAIL fill_nwrites got=%0d want=%0d", wa.size(), NPIX); end
      for (int i = 0; i < NPIX && i < wa.size(); i++) begin
         vec++;
         if (wa[i] !== AW'(exp_addr(i)) || wd[i] !== val || wc[i] != wc[0] + i) begin
            err++; $display("FAIL fill_write[%0d] got=%0d/%h/c%0d want=%0d/%h/c%0d",
                            i, wa[i], wd[i], wc[i], exp_addr(i), val, wc[0] + i);
         end
      end
      vec++; if (dc.size() != 1) begin err++; $display("FAIL fill_done_count got=%0d want=1", dc.size()); end
      vec++; if (busy_o !== 1'b0) begin err++; $display("FAIL fill_busy_after got=%b want=0", busy_o); end
   endtask

   task automatic test_abort();
      clear_rec();
      feed(6, 0, 1'b0);
      @(negedge clk);
      abort = 1'b1; s_valid = 1'b1;
      #1;
      vec++; if (s_ready_o !== 1'b0) begin err++; $display("FAIL abort_s_ready got=%b want=0", s_ready_o); end
      @(negedge clk);
      abort = 1'b0; s_valid = 1'b0;
      repeat (8) @(negedge clk);
      vec++; if (wa.size() != 6) begin err++; $display("FAIL abort_nwrites got=%0d want=6", wa.size()); end
      if (wa.size() >= 6) begin
         vec++; if (wa[5] !== AW'(25)) begin err++; $display("FAIL abort_last_addr got=%0d want=25", wa[5]); end
         vec++; if (wd[5] !== exp_q[5]) begin err++; $display("FAIL abort_last_data got=%h want=%h", wd[5], exp_q[5]); end
      end
      vec++; if (dc.size() != 0) begin err++; $display("FAIL abort_done got=%0d want=0", dc.size()); end
      vec++; if (busy_o !== 1'b0) begin err++; $display("FAIL abort_busy got=%b want=0", busy_o); end
      run_stream(0, 1'b0);
   endtask

   task automatic test_reset_midframe();
      int n;
      clear_rec();
      feed(8, 0, 1'b0);
      @(negedge clk);
      vec++; if (ram_wren_o !== 1'b1) begin err++; $display("FAIL midrst_pre_wren got=%b want=1", ram_wren_o); end
      s_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      vec++;
      if (ram_wren_o !== 1'b0 || s_ready_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
          ram_address_o !== '0 || ram_data_o !== 8'h00) begin
         err++; $display("FAIL midrst_outputs got=w%b r%b b%b d%b a%0d x%h want=all zero",
                         ram_wren_o, s_ready_o, busy_o, done_o, ram_address_o, ram_data_o);
      end
      @(negedge clk); rst_n = 1'b1;
      n = wa.size();
      s_valid = 1'b1;
      repeat (5) @(negedge clk);
      vec++; if (wa.size() != n || busy_o !== 1'b0 || s_ready_o !== 1'b0) begin
         err++; $display("FAIL midrst_idle got=writes%0d busy%b ready%b want=writes%0d busy0 ready0",
                         wa.size() - n, busy_o, s_ready_o, 0);
      end
      s_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; fill_en = 1'b0; abort = 1'b0;
      s_valid = 1'b0; fill_value = 8'h00; s_data = 8'h00;
      test_reset();
      run_stream(0, 1'b0);
      run_stream(1, 1'b0);
      test_fill(8'hA5);
      test_fill(8'($urandom));
      test_abort();
      test_reset_midframe();
      run_stream(0, 1'b1);
      run_stream(2, 1'b0);
      run_stream(2, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
